// File: rtl/sim_exit_pkg.sv
// Shared types and constants for the simulation exit monitor: lifecycle states,
// failure reasons, and the ceiling for the ignored-write counter.
package sim_exit_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REASON_NONE      = 2'd0,
    REASON_TEST_FAIL = 2'd1,
    REASON_WATCHDOG  = 2'd2,
    REASON_PROTOCOL  = 2'd3
  } reason_t;

  localparam logic [7:0] SAT8_MAX = 8'hFF;

endpackage

// File: rtl/sim_watchdog.sv
// Progress watchdog: a saturating stall counter. It flags expiry on the edge
// where the count would reach a nonzero limit, unless that same cycle clears it.
module sim_watchdog #(
  parameter int WDOG_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [WDOG_W-1:0] limit,
  output logic              expire
);

  logic [WDOG_W-1:0] cnt_reg;
  logic [WDOG_W-1:0] cnt_next;

  // The counter sticks at all-ones instead of wrapping back to a small value.
  assign cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + WDOG_W'(1);
  assign expire   = enable && !clear && (limit != '0) && (cnt_next >= limit);

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/sim_exit_monitor.sv
// Decodes tohost writes and watchdog expiry into a sticky pass/fail status.
// The status is published only after a drain window that lets trailing DUT activity settle.
module sim_exit_monitor
  import sim_exit_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int CODE_W       = 31,
  parameter int DRAIN_CYCLES = 16,
  parameter int WDOG_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              progress,
  input  logic [WDOG_W-1:0] wdog_limit,
  output logic              io_success,
  output logic              io_failure,
  output logic [1:0]        fail_reason,
  output logic [CODE_W-1:0] fail_code,
  output logic [7:0]        ignored_cnt,
  output logic              busy
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  state_t              state_reg;
  logic [DRAIN_W-1:0]  drain_cnt_reg;
  logic [7:0]          ignored_reg;
  logic                pend_pass_reg;
  reason_t             pend_reason_reg;
  logic [CODE_W-1:0]   pend_code_reg;
  logic                success_reg;
  logic                failure_reg;
  reason_t             reason_reg;
  logic [CODE_W-1:0]   code_reg;

  logic                accept;
  logic                upper_nz;
  logic [CODE_W-1:0]   wr_code;
  logic                wr_term;
  logic                wdog_expire;
  logic                term_event;
  logic                term_pass;
  reason_t             term_reason;
  logic [CODE_W-1:0]   term_code;

  assign accept  = wr_valid && (state_reg == ST_RUN);
  assign wr_code = wr_data[CODE_W:1];
  assign wr_term = accept && wr_data[0];

  if (DATA_W > CODE_W + 1) begin : g_upper
    assign upper_nz = |wr_data[DATA_W-1:CODE_W+1];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  // Any accepted write counts as progress, so a terminal write always beats expiry.
  sim_watchdog #(.WDOG_W(WDOG_W)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .enable (state_reg == ST_RUN),
    .clear  (progress || accept),
    .limit  (wdog_limit),
    .expire (wdog_expire)
  );

  assign term_event = wr_term || wdog_expire;

  always_comb begin
    term_pass   = 1'b0;
    term_reason = REASON_WATCHDOG;
    term_code   = '0;
    if (wr_term) begin
      if (upper_nz) begin
        term_reason = REASON_PROTOCOL;
      end else if (wr_code == '0) begin
        term_pass   = 1'b1;
        term_reason = REASON_NONE;
      end else begin
        term_reason = REASON_TEST_FAIL;
        term_code   = wr_code;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg       <= ST_RUN;
      drain_cnt_reg   <= '0;
      ignored_reg     <= '0;
      pend_pass_reg   <= 1'b0;
      pend_reason_reg <= REASON_NONE;
      pend_code_reg   <= '0;
      success_reg     <= 1'b0;
      failure_reg     <= 1'b0;
      reason_reg      <= REASON_NONE;
      code_reg        <= '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (accept && !wr_data[0] && (ignored_reg != SAT8_MAX)) begin
            ignored_reg <= ignored_reg + 8'd1;
          end
          if (term_event) begin
            pend_pass_reg   <= term_pass;
            pend_reason_reg <= term_reason;
            pend_code_reg   <= term_code;
            drain_cnt_reg   <= '0;
            if (DRAIN_CYCLES == 0) begin
              state_reg   <= ST_DONE;
              success_reg <= term_pass;
              failure_reg <= !term_pass;
              reason_reg  <= term_reason;
              code_reg    <= term_code;
            end else begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_reg   <= ST_DONE;
            success_reg <= pend_pass_reg;
            failure_reg <= !pend_pass_reg;
            reason_reg  <= pend_reason_reg;
            code_reg    <= pend_code_reg;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign wr_ready    = (state_reg == ST_RUN);
  assign busy        = (state_reg == ST_RUN);
  assign io_success  = success_reg;
  assign io_failure  = failure_reg;
  assign fail_reason = reason_reg;
  assign fail_code   = code_reg;
  assign ignored_cnt = ignored_reg;

endmodule
